// File: rtl/alu_result_stage.sv
// Registered ALU result stage: a 2-entry skid buffer with a registered in_ready, carrying zero/neg flags.
// Optional macro PARITY_FLAG_EN adds a stored parity flag per entry; without it out_parity is tied to 0.
module alu_result_stage #(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_result,
  input  logic [ADDR_W-1:0] in_dest,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_result,
  output logic [ADDR_W-1:0] out_dest,
  output logic              out_zero,
  output logic              out_neg,
  output logic              out_parity
);

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  state_t r_state, w_state_nxt;
  logic   r_in_ready;

  logic [WIDTH-1:0]  r_m_res, r_s_res;
  logic [ADDR_W-1:0] r_m_dest, r_s_dest;
  logic              r_m_zero, r_s_zero, r_m_neg, r_s_neg;

  logic w_in_xfer, w_out_xfer;
  logic w_ld_main, w_ld_skid, w_skid2main;
  logic w_in_zero, w_in_neg;

  assign w_in_xfer  = in_valid & r_in_ready;
  assign w_out_xfer = (r_state != EMPTY) & out_ready;
  // Flags are taken from the incoming word and stored with it.
  assign w_in_zero  = (in_result == '0);
  assign w_in_neg   = in_result[WIDTH-1];

  always_comb begin
    w_state_nxt = r_state;
    w_ld_main   = 1'b0;
    w_ld_skid   = 1'b0;
    w_skid2main = 1'b0;
    case (r_state)
      EMPTY: if (w_in_xfer) begin
        w_ld_main   = 1'b1;
        w_state_nxt = ONE;
      end
      ONE: begin
        if (w_in_xfer && w_out_xfer) begin
          w_ld_main = 1'b1;
        end else if (w_in_xfer) begin
          w_ld_skid   = 1'b1;
          w_state_nxt = FULL;
        end else if (w_out_xfer) begin
          w_state_nxt = EMPTY;
        end
      end
      FULL: if (w_out_xfer) begin
        w_skid2main = 1'b1;
        w_state_nxt = ONE;
      end
      default: w_state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= EMPTY;
      r_in_ready <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_in_ready <= (w_state_nxt != FULL);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_m_res  <= '0;
      r_m_dest <= '0;
      r_m_zero <= 1'b1;
      r_m_neg  <= 1'b0;
      r_s_res  <= '0;
      r_s_dest <= '0;
      r_s_zero <= 1'b1;
      r_s_neg  <= 1'b0;
    end else begin
      if (w_ld_main) begin
        r_m_res  <= in_result;
        r_m_dest <= in_dest;
        r_m_zero <= w_in_zero;
        r_m_neg  <= w_in_neg;
      end else if (w_skid2main) begin
        r_m_res  <= r_s_res;
        r_m_dest <= r_s_dest;
        r_m_zero <= r_s_zero;
        r_m_neg  <= r_s_neg;
      end
      if (w_ld_skid) begin
        r_s_res  <= in_result;
        r_s_dest <= in_dest;
        r_s_zero <= w_in_zero;
        r_s_neg  <= w_in_neg;
      end
    end
  end

`ifdef PARITY_FLAG_EN
  logic r_m_par, r_s_par;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_m_par <= 1'b0;
      r_s_par <= 1'b0;
    end else begin
      if (w_ld_main)        r_m_par <= ^in_result;
      else if (w_skid2main) r_m_par <= r_s_par;
      if (w_ld_skid)        r_s_par <= ^in_result;
    end
  end
  assign out_parity = r_m_par;
`else
  assign out_parity = 1'b0;
`endif

  assign in_ready   = r_in_ready;
  assign out_valid  = (r_state != EMPTY);
  assign out_result = r_m_res;
  assign out_dest   = r_m_dest;
  assign out_zero   = r_m_zero;
  assign out_neg    = r_m_neg;

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed bench for alu_result_stage: handshake, ordering, flags and reset behaviour.
module tb_alu_result_stage;

  logic        clk = 1'b0;
  logic        reset, in_valid, out_ready;
  logic        in_ready, out_valid, out_zero, out_neg, out_parity;
  logic [15:0] in_result, out_result;
  logic [2:0]  in_dest, out_dest;

  int checks = 0;
  int errors = 0;

  alu_result_stage #(.WIDTH(16), .ADDR_W(3)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result), .in_dest(in_dest),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result), .out_dest(out_dest),
    .out_zero(out_zero), .out_neg(out_neg), .out_parity(out_parity)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [15:0] r, input logic [2:0] d);
    in_valid  = v;
    in_result = r;
    in_dest   = d;
  endtask

  logic p7_exp, p3_exp;

  initial begin
`ifdef PARITY_FLAG_EN
    p7_exp = 1'b1;
`else
    p7_exp = 1'b0;
`endif
    p3_exp = 1'b0;

    // 1: reset with in_valid asserted
    reset = 1'b1; out_ready = 1'b0;
    drive(1'b1, 16'h1234, 3'd5);
    @(negedge clk); @(negedge clk);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_zero", {31'd0, out_zero}, 32'd1);
    chk("rst_out_result", {16'd0, out_result}, 32'd0);
    chk("rst_out_dest", {29'd0, out_dest}, 32'd0);
    chk("rst_out_neg", {31'd0, out_neg}, 32'd0);
    chk("rst_out_parity", {31'd0, out_parity}, 32'd0);
    reset = 1'b0;
    drive(1'b0, 16'h0, 3'd0);
    @(negedge clk);
    chk("idle_out_valid", {31'd0, out_valid}, 32'd0);

    // 2: single transfer of a negative value
    drive(1'b1, 16'h8000, 3'd3);
    @(negedge clk);
    drive(1'b0, 16'h0, 3'd0);
    chk("t2_valid", {31'd0, out_valid}, 32'd1);
    chk("t2_result", {16'd0, out_result}, 32'h8000);
    chk("t2_dest", {29'd0, out_dest}, 32'd3);
    chk("t2_neg", {31'd0, out_neg}, 32'd1);
    chk("t2_zero", {31'd0, out_zero}, 32'd0);
    chk("t2_in_ready", {31'd0, in_ready}, 32'd1);
    out_ready = 1'b1;
    @(negedge clk);
    chk("t2_drained", {31'd0, out_valid}, 32'd0);
    out_ready = 1'b0;

    // 3: fill to FULL with backpressure, then drain in order
    drive(1'b1, 16'h00F0, 3'd1);
    @(negedge clk);
    chk("t3_ready_after1", {31'd0, in_ready}, 32'd1);
    drive(1'b1, 16'h0000, 3'd2);
    @(negedge clk);
    chk("t3_ready_full", {31'd0, in_ready}, 32'd0);
    chk("t3_hold_result", {16'd0, out_result}, 32'h00F0);
    drive(1'b1, 16'hDEAD, 3'd7);
    @(negedge clk);
    chk("t3_ignored_ready", {31'd0, in_ready}, 32'd0);
    chk("t3_stable_result", {16'd0, out_result}, 32'h00F0);
    chk("t3_stable_dest", {29'd0, out_dest}, 32'd1);
    chk("t3_first_zero", {31'd0, out_zero}, 32'd0);
    drive(1'b0, 16'h0, 3'd0);
    out_ready = 1'b1;
    @(negedge clk);
    chk("t3_second_valid", {31'd0, out_valid}, 32'd1);
    chk("t3_second_result", {16'd0, out_result}, 32'h0000);
    chk("t3_second_dest", {29'd0, out_dest}, 32'd2);
    chk("t3_second_zero", {31'd0, out_zero}, 32'd1);
    chk("t3_ready_back", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    chk("t3_empty", {31'd0, out_valid}, 32'd0);

    // 4: back-to-back stream with out_ready held high
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 16'(i), 3'(i));
      @(negedge clk);
      chk("t4_valid", {31'd0, out_valid}, 32'd1);
      chk("t4_result", {16'd0, out_result}, 32'(i));
      chk("t4_dest", {29'd0, out_dest}, 32'(i % 8));
      chk("t4_in_ready", {31'd0, in_ready}, 32'd1);
    end
    drive(1'b0, 16'h0, 3'd0);
    @(negedge clk);
    chk("t4_empty", {31'd0, out_valid}, 32'd0);

    // 5: reset while FULL discards both entries
    out_ready = 1'b0;
    drive(1'b1, 16'hAAAA, 3'd4);
    @(negedge clk);
    drive(1'b1, 16'hBBBB, 3'd6);
    @(negedge clk);
    chk("t5_full", {31'd0, in_ready}, 32'd0);
    drive(1'b0, 16'h0, 3'd0);
    reset = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    chk("t5_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("t5_rst_ready", {31'd0, in_ready}, 32'd1);
    chk("t5_rst_result", {16'd0, out_result}, 32'd0);
    chk("t5_rst_zero", {31'd0, out_zero}, 32'd1);
    reset = 1'b0;
    @(negedge clk);
    chk("t5_no_leak", {31'd0, out_valid}, 32'd0);

    // 6: parity flag, second word loaded while first drains
    out_ready = 1'b0;
    drive(1'b1, 16'h0007, 3'd0);
    @(negedge clk);
    chk("t6_par7", {31'd0, out_parity}, {31'd0, p7_exp});
    out_ready = 1'b1;
    drive(1'b1, 16'h0003, 3'd1);
    @(negedge clk);
    chk("t6_res3", {16'd0, out_result}, 32'h0003);
    chk("t6_par3", {31'd0, out_parity}, {31'd0, p3_exp});
    drive(1'b1, 16'hFFFF, 3'd2);
    @(negedge clk);
    chk("t6_negFFFF", {31'd0, out_neg}, 32'd1);
    chk("t6_parFFFF", {31'd0, out_parity}, 32'd0);
    drive(1'b0, 16'h0, 3'd0);
    @(negedge clk);
    chk("t6_empty", {31'd0, out_valid}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
